// File: rtl/cache_fill_if.sv
// Miss/memory/cache-array signal bundle for the cache fill controller.
// CACHE_CRITICAL_WORD_FIRST_EN adds the critical_word_ready signal.
interface cache_fill_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;

  logic              fsm_busy;
  logic              memory_read_req;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] cache_address;
  logic [DATA_W-1:0] cache_write_data;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic              critical_word_ready;
`endif

  // Controller side
  modport master (
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    output critical_word_ready,
`endif
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output memory_read_req,
    output memory_address,
    output write_data_array,
    output write_tag_array,
    output cache_address,
    output cache_write_data
  );

  // Cache / memory side
  modport slave (
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    input  critical_word_ready,
`endif
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  memory_read_req,
    input  memory_address,
    input  write_data_array,
    input  write_tag_array,
    input  cache_address,
    input  cache_write_data
  );

endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a whole block from pipelined memory, writes data then tag.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN: fill starts at the missed word and wraps.
module cache_fill_fsm #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  cache_fill_if.master  bus
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned BASE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t            state;
  logic [BASE_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  crit;
`endif

  logic              req_fire;
  logic              rcv_fire;
  logic              rcv_last;
  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  rcv_off;

  // Request/return qualification and word offsets within the block
  always_comb begin
    req_fire = (state == FILL) && (req_cnt < CNT_W'(BLOCK_WORDS));
    rcv_fire = (state == FILL) && bus.memory_data_valid && (rcv_cnt < CNT_W'(BLOCK_WORDS));
    rcv_last = rcv_fire && (rcv_cnt == CNT_W'(BLOCK_WORDS - 1));
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    req_off  = OFF_W'(crit + req_cnt[OFF_W-1:0]);
    rcv_off  = OFF_W'(crit + rcv_cnt[OFF_W-1:0]);
`else
    req_off  = req_cnt[OFF_W-1:0];
    rcv_off  = rcv_cnt[OFF_W-1:0];
`endif
  end

  // State, block base and request/return counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      crit    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            base    <= bus.miss_address[ADDR_W-1:OFF_W];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            crit    <= bus.miss_address[OFF_W-1:0];
`endif
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (req_fire) begin
            req_cnt <= req_cnt + CNT_W'(1);
          end
          if (rcv_fire) begin
            rcv_cnt <= rcv_cnt + CNT_W'(1);
          end
          if (rcv_last) begin
            state <= TAG;
          end
        end
        TAG: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write strobes and data path follow the memory return in the same cycle
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.memory_read_req  = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.cache_address    = '0;
    bus.cache_write_data = bus.memory_data;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    bus.critical_word_ready = 1'b0;
`endif
    case (state)
      FILL: begin
        bus.fsm_busy         = 1'b1;
        bus.memory_read_req  = req_fire;
        bus.memory_address   = {base, req_off};
        bus.write_data_array = rcv_fire;
        bus.cache_address    = {base, rcv_off};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        bus.critical_word_ready = rcv_fire && (rcv_cnt == '0);
`endif
      end
      TAG: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
        bus.cache_address   = {base, OFF_W'(0)};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: pipelined memory responder plus scoreboard monitor.
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data  = '0;
  logic        man_valid = 1'b0;
  assign bus.memory_data_valid = rsp_valid | man_valid;
  assign bus.memory_data       = rsp_data;

  // Responder knobs and state
  int lat        = 4;
  int gap_mode   = 0;
  int gap_left   = 0;
  int extra_left = 0;
  int delivered  = 0;
  logic [15:0] pend_a[$];
  int          pend_c[$];

  // Scoreboard
  logic [15:0] exp_req[$];
  logic [15:0] exp_wr[$];
  logic [15:0] exp_tag[$];
  int start_cycs[$];
  int tag_cycs[$];
  int busy_runs[$];
  int wr_total  = 0;
  int tag_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: record requests, return them in order after lat cycles
  always begin
    @(negedge clk);
    if (bus.memory_read_req) begin
      pend_a.push_back(bus.memory_address);
      pend_c.push_back(cyc);
    end
  end

  always begin
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (gap_left > 0) begin
      gap_left--;
    end else if (pend_a.size() > 0 && pend_c[0] + lat <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = pend_a.pop_front();
      void'(pend_c.pop_front());
      delivered++;
      if (gap_mode != 0) gap_left = int'($urandom_range(0, 3));
    end else if (pend_a.size() == 0 && extra_left > 0 && delivered >= 8) begin
      rsp_valid = 1'b1;
      rsp_data  = 16'hDEAD;
      extra_left--;
    end
  end

  // Monitor: compare every DUT action against the scoreboard
  int req_run = 0;
  int busy_run = 0;
  int fill_wr_idx = 0;
  always begin
    logic [15:0] e;
    @(negedge clk);
    if (bus.memory_read_req) begin
      if (req_run == 0) start_cycs.push_back(cyc);
      req_run++;
      if (exp_req.size() == 0) check("req_unexpected", 32'(bus.memory_address), 32'hFFFF_FFFF);
      else begin
        e = exp_req.pop_front();
        check("req_addr", 32'(bus.memory_address), 32'(e));
      end
    end else begin
      if (req_run != 0 && !rst) check("req_run_len", 32'(req_run), 32'd8);
      req_run = 0;
    end
    if (bus.fsm_busy) busy_run++;
    else begin
      if (busy_run != 0 && !rst) busy_runs.push_back(busy_run);
      busy_run = 0;
    end
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    check("crit_ready", 32'(bus.critical_word_ready),
          32'(bus.write_data_array && fill_wr_idx == 0));
`endif
    if (bus.write_data_array) begin
      wr_total++;
      fill_wr_idx++;
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(bus.cache_address), 32'hFFFF_FFFF);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(bus.cache_address), 32'(e));
        check("wr_data", 32'(bus.cache_write_data), 32'(e));
      end
    end
    if (bus.write_tag_array) begin
      tag_total++;
      tag_cycs.push_back(cyc);
      fill_wr_idx = 0;
      check("tag_busy", 32'(bus.fsm_busy), 32'd1);
      if (exp_tag.size() == 0) check("tag_unexpected", 32'(bus.cache_address), 32'hFFFF_FFFF);
      else begin
        e = exp_tag.pop_front();
        check("tag_addr", 32'(bus.cache_address), 32'(e));
      end
    end
    if (rst) fill_wr_idx = 0;
  end

  task automatic push_exp(input logic [15:0] a);
    logic [2:0]  o;
    logic [2:0]  c;
    logic [15:0] e;
    c = a[2:0];
    for (int i = 0; i < 8; i++) begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      o = 3'(c + 3'(i));
`else
      o = 3'(i);
`endif
      e = {a[15:3], o};
      exp_req.push_back(e);
      exp_wr.push_back(e);
    end
    exp_tag.push_back({a[15:3], 3'b000});
  endtask

  task automatic start_miss(input logic [15:0] a);
    @(posedge clk); #1;
    delivered = 0;
    push_exp(a);
    bus.miss_detected = 1'b1;
    bus.miss_address  = a;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((bus.fsm_busy || exp_req.size() != 0 || exp_wr.size() != 0 || exp_tag.size() != 0 ||
            pend_a.size() != 0 || extra_left != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_in_budget", 32'(n < budget), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.fsm_busy), 32'd0);
    check({tag, "_req"},   32'(bus.memory_read_req), 32'd0);
    check({tag, "_maddr"}, 32'(bus.memory_address), 32'd0);
    check({tag, "_wda"},   32'(bus.write_data_array), 32'd0);
    check({tag, "_wta"},   32'(bus.write_tag_array), 32'd0);
    check({tag, "_caddr"}, 32'(bus.cache_address), 32'd0);
  endtask

  initial begin
    int w0, t0, n;
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_wdata", 32'(bus.cache_write_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    man_valid = 1'b1;
    @(negedge clk);
    check("idle_valid_ignored", 32'(bus.write_data_array), 32'd0);
    @(posedge clk); #1;
    man_valid = 1'b0;

    // Basic fill, latency 4
    lat = 4;
    w0 = wr_total; t0 = tag_total;
    start_miss(16'h1238);
    wait_done(200);
    check("basic_writes", 32'(wr_total - w0), 32'd8);
    check("basic_tags", 32'(tag_total - t0), 32'd1);
    check("basic_busy_len", 32'(busy_runs[$]), 32'd13);

    // Minimum fill time, latency 1
    lat = 1;
    start_miss(16'h0100);
    wait_done(200);
    check("min_busy_len", 32'(busy_runs[$]), 32'd10);

    // Back-to-back misses, second held asserted
    lat = 2;
    start_cycs.delete();
    tag_cycs.delete();
    push_exp(16'h0010);
    push_exp(16'h0020);
    @(posedge clk); #1;
    delivered = 0;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0010;
    @(posedge clk); #1;
    bus.miss_address  = 16'h0020;
    n = 0;
    while (start_cycs.size() < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.miss_detected = 1'b0;
    check("b2b_second_start", 32'(start_cycs.size()), 32'd2);
    wait_done(200);
    if (start_cycs.size() >= 2 && tag_cycs.size() >= 1)
      check("b2b_accept_cycle", 32'(start_cycs[1]), 32'(tag_cycs[0] + 2));

    // Irregular return gaps plus extra returns
    lat = 1;
    gap_mode = 1;
    w0 = wr_total; t0 = tag_total;
    start_miss(16'h0300);
    extra_left = 2;
    wait_done(300);
    gap_mode = 0;
    check("irr_writes", 32'(wr_total - w0), 32'd8);
    check("irr_tags", 32'(tag_total - t0), 32'd1);

    // Reset after three returns
    lat = 4;
    w0 = wr_total; t0 = tag_total;
    start_miss(16'h4000);
    n = 0;
    while (wr_total - w0 < 3 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("midrst_three_writes", 32'(wr_total - w0), 32'd3);
    rst = 1'b1;
    exp_req.delete(); exp_wr.delete(); exp_tag.delete();
    pend_a.delete(); pend_c.delete();
    #1;
    check_idle_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_tag", 32'(tag_total - t0), 32'd0);
    w0 = wr_total; t0 = tag_total;
    start_miss(16'h4000);
    wait_done(200);
    check("refill_writes", 32'(wr_total - w0), 32'd8);
    check("refill_tags", 32'(tag_total - t0), 32'd1);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    // Critical word first: order FD, FE, FF, F8..FC; tag at F8
    lat = 2;
    w0 = wr_total; t0 = tag_total;
    start_miss(16'h00FD);
    wait_done(200);
    check("crit_writes", 32'(wr_total - w0), 32'd8);
    check("crit_tags", 32'(tag_total - t0), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
